// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write FIFO between the memory stage and data memory. Stores are
//   captured at the tail and drained from the head one per cycle under a
//   ready handshake. Loads are checked against the buffered stores so the
//   youngest same-address store is forwarded (full word) or flagged as a
//   hazard (partial word).
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   capture_store, store_*_in        push request and store entry
//   load_request, load_addr          forwarding query
//   buffer_forward_valid/_data       forwarded full-word store data
//   load_hazard                      youngest match is partial; stall the load
//   buffer_full, buffer_empty        decodes of the registered count
//   wr_enable, wr_addr, wr_data,
//   write_byte_enable                head entry presented to memory
//   mem_wr_ready                     memory accepts the head this cycle
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_store,
  input  logic [31:0] store_addr_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  store_byte_en_in,
  input  logic        load_request,
  input  logic [31:0] load_addr,
  output logic        buffer_forward_valid,
  output logic [31:0] buffer_forward_data,
  output logic        load_hazard,
  output logic        buffer_full,
  output logic        buffer_empty,
  output logic        wr_enable,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  write_byte_enable,
  input  logic        mem_wr_ready
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic push;
  logic pop;

  assign buffer_full  = (count == (PW+1)'(DEPTH));
  assign buffer_empty = (count == '0);
  assign wr_enable    = !buffer_empty;

  assign pop  = wr_enable && mem_wr_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push = capture_store && (!buffer_full || pop);

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage: contents are only ever observed through count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= store_addr_in;
      data_q[tail] <= store_data_in;
      be_q[tail]   <= store_byte_en_in;
    end
  end

  // Drain port straight from the head entry, zeroed when nothing is valid
  always_comb begin
    wr_addr           = '0;
    wr_data           = '0;
    write_byte_enable = '0;
    if (wr_enable) begin
      wr_addr           = addr_q[head];
      wr_data           = data_q[head];
      write_byte_enable = be_q[head];
    end
  end

  // Forwarding: walk entries oldest to youngest so the last hit wins
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (((PW+1)'(k) < count) && (addr_q[idx] == load_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  always_comb begin
    buffer_forward_valid = 1'b0;
    buffer_forward_data  = '0;
    load_hazard          = 1'b0;
    if (load_request && hit) begin
      if (be_q[hit_idx] == 4'b1111) begin
        buffer_forward_valid = 1'b1;
        buffer_forward_data  = data_q[hit_idx];
      end else begin
        load_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_store;
  logic [31:0] store_addr_in;
  logic [31:0] store_data_in;
  logic [3:0]  store_byte_en_in;
  logic        load_request;
  logic [31:0] load_addr;
  logic        buffer_forward_valid;
  logic [31:0] buffer_forward_data;
  logic        load_hazard;
  logic        buffer_full;
  logic        buffer_empty;
  logic        wr_enable;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  write_byte_enable;
  logic        mem_wr_ready;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .capture_store        (capture_store),
    .store_addr_in        (store_addr_in),
    .store_data_in        (store_data_in),
    .store_byte_en_in     (store_byte_en_in),
    .load_request         (load_request),
    .load_addr            (load_addr),
    .buffer_forward_valid (buffer_forward_valid),
    .buffer_forward_data  (buffer_forward_data),
    .load_hazard          (load_hazard),
    .buffer_full          (buffer_full),
    .buffer_empty         (buffer_empty),
    .wr_enable            (wr_enable),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .write_byte_enable    (write_byte_enable),
    .mem_wr_ready         (mem_wr_ready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit l, input logic [31:0] la,
                       input bit r);
    capture_store    = c;
    store_addr_in    = a;
    store_data_in    = d;
    store_byte_en_in = b;
    load_request     = l;
    load_addr        = la;
    mem_wr_ready     = r;
  endtask

  // Compare all outputs against the queue model, then clock and update it.
  task automatic cycle_check();
    logic        e_fv, e_hz;
    logic [31:0] e_fd;
    ent_t        h;
    bit          do_pop, do_push;
    #1;
    e_fv = 1'b0; e_hz = 1'b0; e_fd = '0;
    if (load_request) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == load_addr) begin
          if (q[i].be == 4'hF) begin
            e_fv = 1'b1;
            e_fd = q[i].data;
          end else begin
            e_hz = 1'b1;
          end
          break;
        end
      end
    end
    h = (q.size() > 0) ? q[0] : '0;
    chk("buffer_empty", 32'(buffer_empty), 32'(q.size() == 0));
    chk("buffer_full",  32'(buffer_full),  32'(q.size() == DEPTH));
    chk("wr_enable",    32'(wr_enable),    32'(q.size() != 0));
    chk("wr_addr",      wr_addr,           h.addr);
    chk("wr_data",      wr_data,           h.data);
    chk("write_byte_enable", 32'(write_byte_enable), 32'(h.be));
    chk("fwd_valid",    32'(buffer_forward_valid), 32'(e_fv));
    chk("fwd_data",     buffer_forward_data, e_fd);
    chk("load_hazard",  32'(load_hazard),  32'(e_hz));
    do_pop  = (q.size() > 0) && mem_wr_ready;
    do_push = capture_store && ((q.size() < DEPTH) || do_pop);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({store_addr_in, store_data_in, store_byte_en_in});
    end
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, r);
      cycle_check();
    end
  endtask

  initial begin
    logic [3:0] be_tab [4];
    be_tab[0] = 4'b1111; be_tab[1] = 4'b0011; be_tab[2] = 4'b0001; be_tab[3] = 4'b0000;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();

    // reset state
    idle(0, 1);

    // store to empty buffer, drains the next cycle
    drive(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    cycle_check();
    idle(1, 2);

    // fill, overflow attempt, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 0, 0, 0);
      cycle_check();
    end
    drive(1, 32'h10, 32'hBAD0BAD0, 4'hF, 1, 32'h8, 0);
    cycle_check();
    drive(0, 0, 0, 0, 1, 32'h10, 0);
    cycle_check();
    idle(1, 5);

    // youngest of two same-address stores is forwarded
    drive(1, 32'h200, 32'h11111111, 4'hF, 0, 0, 0);
    cycle_check();
    drive(1, 32'h200, 32'h22222222, 4'hF, 0, 0, 0);
    cycle_check();
    drive(0, 0, 0, 0, 1, 32'h200, 0);
    cycle_check();
    idle(1, 3);

    // partial store causes a hazard, visible even in its pop cycle
    drive(1, 32'h300, 32'h000000AB, 4'b0001, 0, 0, 0);
    cycle_check();
    drive(0, 0, 0, 0, 1, 32'h300, 0);
    cycle_check();
    drive(0, 0, 0, 0, 1, 32'h300, 1);
    cycle_check();
    drive(0, 0, 0, 0, 1, 32'h300, 1);
    cycle_check();

    // full with simultaneous push and pop, across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h50 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF, 0, 0, 0);
      cycle_check();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h40 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'hF, 1, 32'h40, 1);
      cycle_check();
    end
    idle(1, 5);

    // reset mid-operation discards entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h600 + 32'(i * 4), 32'hE000_0000 + 32'(i), 4'hF, 0, 0, 0);
      cycle_check();
    end
    rst = 1'b1;
    drive(1, 32'h700, 32'h77777777, 4'hF, 1, 32'h604, 1);
    cycle_check();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h604, 0);
    cycle_check();

    // randomized traffic over a small address pool
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 4, $urandom,
            be_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 7)) * 4, ($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 63) == 0);
      cycle_check();
      rst = 1'b0;
    end
    idle(1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
